mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port matrix block RAM (signals ramEN/readEN/writeEN/addr/data_in/data_out, one-cycle registered read).
- Requester A is the matrix loader/writer; requester B is the compute engine.
- Shares the one RAM port using round-robin priority and issues at most one access per cycle.
- Tracks outstanding reads and returns each read's data to the requester that issued it, with a valid strobe.

---
 rtl/mem_arbiter_if.sv | 58 +++++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Requester A/B handshake bundle plus the single-port RAM
//               command/data port shared by mem_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int DW = 8,
    parameter int AW = 6
);
    // Requester A (matrix loader/writer)
    logic          reqA;
    logic          weA;
    logic [AW-1:0] addrA;
    logic [DW-1:0] wdataA;
    logic          lockA;
    logic          gntA;
    logic          rvalidA;
    logic [DW-1:0] rdataA;

    // Requester B (compute engine)
    logic          reqB;
    logic          weB;
    logic [AW-1:0] addrB;
    logic [DW-1:0] wdataB;
    logic          lockB;
    logic          gntB;
    logic          rvalidB;
    logic [DW-1:0] rdataB;

    // Block RAM port
    logic          ramEN;
    logic          writeEN;
    logic          readEN;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memDataIn;
    logic [DW-1:0] memDataOut;

    modport slave (
        input  reqA, weA, addrA, wdataA, lockA,
        input  reqB, weB, addrB, wdataB, lockB,
        input  memDataOut,
        output gntA, rvalidA, rdataA,
        output gntB, rvalidB, rdataB,
        output ramEN, writeEN, readEN, memAddr, memDataIn
    );

    modport master (
        output reqA, weA, addrA, wdataA, lockA,
        output reqB, weB, addrB, wdataB, lockB,
        output memDataOut,
        input  gntA, rvalidA, rdataA,
        input  gntB, rvalidB, rdataB,
        input  ramEN, writeEN, readEN, memAddr, memDataIn
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin two-requester arbiter/sequencer for a single-port
//               block RAM with a one-cycle registered read. Define
//               BURST_LOCK_EN to enable bounded burst locking (MAX_BURST).
// Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int DW        = 8,
    parameter int AW        = 6,
    parameter int MAX_BURST = 4
) (
    input  wire          clk,
    input  wire          rst_n,
    mem_arbiter_if.slave bus
);

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    owner_t        r_last;
    logic          w_prefer_a;
    logic          w_hold_last;
    logic          w_gnt_a;
    logic          w_gnt_b;
    logic          w_accept;
    owner_t        w_sel_own;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    logic          r_en;
    logic          r_we;
    logic          r_re;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_din;

    logic          r_tag1_rd;
    owner_t        r_tag1_own;
    logic          r_tag2_rd;
    owner_t        r_tag2_own;

`ifdef BURST_LOCK_EN
    localparam int                 c_CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_BURST);

    logic [c_CNT_W-1:0] r_burst_cnt;
    logic               w_sel_lock;

    // r_burst_cnt counts consecutive locked grants to r_last; saturates at MAX
    assign w_sel_lock  = w_gnt_b ? bus.lockB : bus.lockA;
    assign w_hold_last = (r_burst_cnt != '0) && (r_burst_cnt < c_MAX_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_cnt <= '0;
        end else if (!w_accept || !w_sel_lock) begin
            r_burst_cnt <= '0;
        end else if (w_sel_own != r_last) begin
            r_burst_cnt <= c_CNT_W'(1);
        end else if (r_burst_cnt != c_MAX_CNT) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
        end
    end
`else
    logic w_unused_lock;

    assign w_hold_last   = 1'b0;
    assign w_unused_lock = bus.lockA ^ bus.lockB ^ MAX_BURST[0];
`endif

    always_comb begin
        w_prefer_a = w_hold_last ? (r_last == OWN_A) : (r_last == OWN_B);
        w_gnt_a    = bus.reqA && (!bus.reqB || w_prefer_a);
        w_gnt_b    = bus.reqB && !w_gnt_a;
    end

    assign w_accept    = w_gnt_a | w_gnt_b;
    assign w_sel_own   = w_gnt_b ? OWN_B : OWN_A;
    assign w_sel_we    = w_gnt_b ? bus.weB    : bus.weA;
    assign w_sel_addr  = w_gnt_b ? bus.addrB  : bus.addrA;
    assign w_sel_wdata = w_gnt_b ? bus.wdataB : bus.wdataA;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= OWN_B;
            r_en       <= 1'b0;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_addr     <= '0;
            r_din      <= '0;
            r_tag1_rd  <= 1'b0;
            r_tag1_own <= OWN_A;
            r_tag2_rd  <= 1'b0;
            r_tag2_own <= OWN_A;
        end else begin
            if (w_accept) begin
                r_last     <= w_sel_own;
                r_en       <= 1'b1;
                r_we       <= w_sel_we;
                r_re       <= !w_sel_we;
                r_addr     <= w_sel_addr;
                r_din      <= w_sel_wdata;
                r_tag1_rd  <= !w_sel_we;
                r_tag1_own <= w_sel_own;
            end else begin
                r_en       <= 1'b0;
                r_we       <= 1'b0;
                r_re       <= 1'b0;
                r_addr     <= '0;
                r_din      <= '0;
                r_tag1_rd  <= 1'b0;
                r_tag1_own <= OWN_A;
            end
            // Tag advances in step with the RAM's output register
            r_tag2_rd  <= r_tag1_rd;
            r_tag2_own <= r_tag1_own;
        end
    end

    assign bus.gntA      = w_gnt_a;
    assign bus.gntB      = w_gnt_b;
    assign bus.ramEN     = r_en;
    assign bus.writeEN   = r_we;
    assign bus.readEN    = r_re;
    assign bus.memAddr   = r_addr;
    assign bus.memDataIn = r_din;
    assign bus.rvalidA   = r_tag2_rd && (r_tag2_own == OWN_A);
    assign bus.rvalidB   = r_tag2_rd && (r_tag2_own == OWN_B);
    assign bus.rdataA    = bus.memDataOut;
    assign bus.rdataB    = bus.memDataOut;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: directed scenarios plus
//               randomized traffic against a transaction-level model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int DW        = 8;
    localparam int AW        = 6;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    mem_arbiter #(.DW(DW), .AW(AW), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Single-port RAM with registered read
    logic [DW-1:0] ram [0:63];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (bus.ramEN) begin
            if (bus.writeEN) ram[bus.memAddr] <= bus.memDataIn;
            if (bus.readEN)  ram_q <= ram[bus.memAddr];
        end
    end
    assign bus.memDataOut = ram_q;

    // Transaction-level model
    typedef struct {
        int            cyc;
        logic          own;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          rq[$];
    logic [DW-1:0] m_mem [0:63];
    logic          m_last;      // 0 = A, 1 = B
    int            m_streak;
    int            cyc;
    logic          e_en, e_we, e_re;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic          p_val, p_own, p_we, p_lock;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_din;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last   = 1'b1;
        m_streak = 0;
        rq.delete();
        e_en = 0; e_we = 0; e_re = 0; e_addr = '0; e_din = '0;
        p_val = 0;
    endtask

    task automatic preload(input int a, input logic [DW-1:0] d);
        ram[a]   = d;
        m_mem[a] = d;
    endtask

    // Applies the access accepted in the previous cycle
    task automatic commit();
        cyc++;
        if (p_val) begin
            e_en = 1; e_we = p_we; e_re = !p_we; e_addr = p_addr; e_din = p_din;
            if (p_we) m_mem[p_addr] = p_din;
            else      rq.push_back('{cyc + 1, p_own, m_mem[p_addr]});
            if (!p_lock)              m_streak = 0;
            else if (p_own != m_last) m_streak = 1;
            else if (m_streak < MAX_BURST) m_streak = m_streak + 1;
            m_last = p_own;
        end else begin
            e_en = 0; e_we = 0; e_re = 0; e_addr = '0; e_din = '0;
            m_streak = 0;
        end
        p_val = 0;
    endtask

    task automatic check_cycle();
        logic pa, ga, gb, xa, xb;
        logic [DW-1:0] xd;
        pa = (m_last == 1'b1);
`ifdef BURST_LOCK_EN
        if (m_streak > 0 && m_streak < MAX_BURST) pa = (m_last == 1'b0);
`endif
        ga = bus.reqA && (!bus.reqB || pa);
        gb = bus.reqB && !ga;
        chk("gntA", bus.gntA, ga);
        chk("gntB", bus.gntB, gb);
        chk("ramEN", bus.ramEN, e_en);
        chk("writeEN", bus.writeEN, e_we);
        chk("readEN", bus.readEN, e_re);
        chk("memAddr", bus.memAddr, e_addr);
        chk("memDataIn", bus.memDataIn, e_din);
        xa = 0; xb = 0; xd = '0;
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            xa = !rq[0].own;
            xb = rq[0].own;
            xd = rq[0].data;
            void'(rq.pop_front());
        end
        chk("rvalidA", bus.rvalidA, xa);
        chk("rvalidB", bus.rvalidB, xb);
        if (xa) chk("rdataA", bus.rdataA, xd);
        if (xb) chk("rdataB", bus.rdataB, xd);
        p_val  = ga | gb;
        p_own  = gb;
        p_we   = gb ? bus.weB    : bus.weA;
        p_addr = gb ? bus.addrB  : bus.addrA;
        p_din  = gb ? bus.wdataB : bus.wdataA;
        p_lock = gb ? bus.lockB  : bus.lockA;
    endtask

    task automatic drive(input logic ra, wa, input logic [AW-1:0] aa, input logic [DW-1:0] da, input logic la,
                         input logic rb, wb, input logic [AW-1:0] ab, input logic [DW-1:0] db, input logic lb);
        bus.reqA = ra; bus.weA = wa; bus.addrA = aa; bus.wdataA = da; bus.lockA = la;
        bus.reqB = rb; bus.weB = wb; bus.addrB = ab; bus.wdataB = db; bus.lockB = lb;
    endtask

    task automatic step(input logic ra, wa, input logic [AW-1:0] aa, input logic [DW-1:0] da, input logic la,
                        input logic rb, wb, input logic [AW-1:0] ab, input logic [DW-1:0] db, input logic lb);
        @(posedge clk); #1;
        commit();
        drive(ra, wa, aa, da, la, rb, wb, ab, db, lb);
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle();
        step(0, 0, '0, '0, 0, 0, 0, '0, '0, 0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ramEN"}, bus.ramEN, 0);
        chk({nm, "_readEN"}, bus.readEN, 0);
        chk({nm, "_writeEN"}, bus.writeEN, 0);
        chk({nm, "_memAddr"}, bus.memAddr, 0);
        chk({nm, "_rvalidA"}, bus.rvalidA, 0);
        chk({nm, "_rvalidB"}, bus.rvalidB, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, '0, '0, 0, 0, 0, '0, '0, 0);
        model_reset();
        #1;
        chk_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    logic          ra, wa, la, rb, wb, lb;
    logic [AW-1:0] aa, ab;
    logic [DW-1:0] da, db;
    logic [9:0]    pat;

    initial begin
        cyc = 0;
        for (int i = 0; i < 64; i++) preload(i, 8'(i * 7 + 3));
        do_reset();

        // Single read with 2-cycle latency
        preload(5, 8'h3C);
        step(1, 0, 6'd5, '0, 0, 0, 0, '0, '0, 0);
        chk("t1_gntA", bus.gntA, 1);
        idle();
        chk("t1_ramEN", bus.ramEN, 1);
        chk("t1_readEN", bus.readEN, 1);
        chk("t1_memAddr", bus.memAddr, 5);
        idle();
        chk("t1_rvalidA", bus.rvalidA, 1);
        chk("t1_rdataA", bus.rdataA, 8'h3C);
        chk("t1_rvalidB", bus.rvalidB, 0);

        // Write then read-after-write
        step(1, 1, 6'd10, 8'hA5, 0, 0, 0, '0, '0, 0);
        chk("t2_gnt_wr", bus.gntA, 1);
        step(1, 0, 6'd10, '0, 0, 0, 0, '0, '0, 0);
        chk("t2_gnt_rd", bus.gntA, 1);
        idle();
        idle();
        chk("t2_rvalidA", bus.rvalidA, 1);
        chk("t2_rdataA", bus.rdataA, 8'hA5);

        // Contended reads alternate
        do_reset();
        preload(1, 8'h11);
        preload(2, 8'h22);
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 6'd1, '0, 0, 1, 0, 6'd2, '0, 0);
            chk("t3_gntA", bus.gntA, (i % 2 == 0));
        end
        idle();
        chk("t3_last_rvalidA", bus.rvalidA, 1);
        chk("t3_last_rdataA", bus.rdataA, 8'h11);
        idle();
        chk("t3_last_rvalidB", bus.rvalidB, 1);
        chk("t3_last_rdataB", bus.rdataB, 8'h22);

        // B alone, then contention goes to A
        for (int i = 0; i < 3; i++) begin
            step(0, 0, '0, '0, 0, 1, 0, 6'd7, '0, 0);
            chk("t4_gntB", bus.gntB, 1);
        end
        step(1, 0, 6'd8, '0, 0, 1, 0, 6'd7, '0, 0);
        chk("t4_gntA", bus.gntA, 1);
        idle();
        idle();

        // Reset while a read is in flight
        step(1, 0, 6'd5, '0, 0, 0, 0, '0, '0, 0);
        idle();
        chk("t5_ramEN_pre", bus.ramEN, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_zero("t5_async");
        @(posedge clk); #1;
        chk("t5_no_rvalidA", bus.rvalidA, 0);
        rst_n = 1'b1;
        idle();
        step(1, 0, 6'd3, '0, 0, 1, 0, 6'd4, '0, 0);
        chk("t5_first_gntA", bus.gntA, 1);
        idle();
        idle();

        // Burst lock pattern
        do_reset();
`ifdef BURST_LOCK_EN
        pat = 10'b0111101111;
`else
        pat = 10'b0101010101;
`endif
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 6'd3, '0, 1, 1, 0, 6'd4, '0, 0);
            chk("t6_gntA", bus.gntA, pat[i]);
        end
        idle();
        idle();

        // Randomized traffic; a pending request is held until granted
        do_reset();
        ra = 0; rb = 0; wa = 0; wb = 0; la = 0; lb = 0;
        aa = '0; ab = '0; da = '0; db = '0;
        for (int i = 0; i < 600; i++) begin
            if (!ra || (p_val && !p_own)) begin
                ra = ($urandom_range(0, 3) != 0);
                wa = ($urandom_range(0, 1) != 0);
                aa = 6'($urandom_range(0, 7));
                da = 8'($urandom_range(0, 255));
                la = ($urandom_range(0, 2) != 0);
            end
            if (!rb || (p_val && p_own)) begin
                rb = ($urandom_range(0, 3) != 0);
                wb = ($urandom_range(0, 1) != 0);
                ab = 6'($urandom_range(0, 7));
                db = 8'($urandom_range(0, 255));
                lb = ($urandom_range(0, 2) != 0);
            end
            step(ra, wa, aa, da, la, rb, wb, ab, db, lb);
        end
        idle();
        idle();
        idle();
        chk("rsp_queue_drained", rq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
